simple_bus_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one parameterised simple_bus data

---
 rtl/simple_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_simple_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter
//   Round-robin arbiter that shares one simple_bus data channel among NREQ
//   requesters. One owner is granted at a time. The owner's data is forwarded
//   with a valid/ready handshake, and the arbiter returns to IDLE to
//   re-arbitrate.
//
// Parameters
//   NREQ      number of requesters (2..16)
//   WIDTH     shared bus data width
//   MAX_BURST max beats per locked tenure (lock build only, >=1)
//
// Configuration macro
//   SIMPLE_BUS_ARB_LOCK_EN  when defined, a locked owner keeps the grant for
//                           up to MAX_BURST back-to-back beats. When undefined,
//                           lock is ignored and every tenure is one beat.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester level request
//   lock       per-requester burst-lock request
//   req_data   requester i data at [i*WIDTH +: WIDTH]
//   req_ack    beat accepted for requester i (combinational)
//   gnt        one-hot registered grant
//   owner      index of the current grant holder
//   bus_valid  shared bus data valid
//   bus_data   shared bus data
//   bus_ready  shared bus consumer ready
module simple_bus_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     bus_valid,
  output logic [WIDTH-1:0]         bus_data,
  input  logic                     bus_ready
);

  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  int unsigned     cand;
  logic [OW-1:0]   next_ptr;
  logic            beat;
  logic [WIDTH-1:0] data_arr [NREQ];

`ifdef SIMPLE_BUS_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  logic [CW-1:0]   cnt_q, cnt_d;
`else
  logic            unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan requesters starting at the rr pointer and wrap at NREQ. The wrap is
  // explicit so that a non-power-of-two NREQ never yields an index past NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req[OW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = OW'(cand);
      end
    end
  end

  assign next_ptr = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);
  assign beat     = (state_q == XFER) && bus_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef SIMPLE_BUS_ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef SIMPLE_BUS_ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef SIMPLE_BUS_ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = XFER;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
`ifdef SIMPLE_BUS_ARB_LOCK_EN
          cnt_d            = '0;
`endif
        end
      end
      XFER: begin
        if (beat) begin
`ifdef SIMPLE_BUS_ARB_LOCK_EN
          // cnt_q counts completed beats before this one. Holding while
          // cnt_q < MAX_BURST-1 gives MAX_BURST beats per tenure. An owner
          // that drops req on the beat still releases.
          if (req[owner_q] && lock[owner_q] && (cnt_q < CW'(MAX_BURST-1))) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = next_ptr;
          end
`else
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
`endif
        end else if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    owner     = owner_q;
    bus_valid = (state_q == XFER);
    bus_data  = '0;
    req_ack   = '0;
    if (state_q == XFER) begin
      bus_data         = data_arr[owner_q];
      req_ack[owner_q] = bus_ready;
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
module tb_simple_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           bus_valid;
  logic [W-1:0]   bus_data;
  logic           bus_ready;

  typedef struct {
    int unsigned own;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  simple_bus_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .gnt       (gnt),
    .owner     (owner),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int unsigned i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic push(input int unsigned o, input logic [W-1:0] d);
    exp_t e;
    e.own  = o;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, "_gnt"},   32'(gnt), 0);
    chk({tag, "_valid"}, 32'(bus_valid), 0);
    chk({tag, "_ack"},   32'(req_ack), 0);
  endtask

  task automatic check_xfer(input string tag, input int unsigned o,
                            input logic [W-1:0] d, input logic rdy);
    logic [N-1:0] g;
    g    = '0;
    g[o] = 1'b1;
    #1;
    chk({tag, "_gnt"},   32'(gnt), 32'(g));
    chk({tag, "_owner"}, 32'(owner), o);
    chk({tag, "_valid"}, 32'(bus_valid), 1);
    chk({tag, "_data"},  32'(bus_data), 32'(d));
    chk({tag, "_ack"},   32'(req_ack), rdy ? 32'(g) : 0);
  endtask

  // Scoreboard consumer: every accepted beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_valid === 1'b1 && bus_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_owner", 32'(owner), e.own);
        chk("sb_data",  32'(bus_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; req_data = '0; bus_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_data", 32'(bus_data), 0);
    chk("rst_ack", 32'(req_ack), 0);

    // Single request: one beat, then release.
    rst_n = 1'b1;
    req = 4'b0001; set_data(0, 8'hA5); bus_ready = 1'b1;
    push(0, 8'hA5);
    check_idle("t1_idle");
    tick();
    req = 4'b0000;
    check_xfer("t1_xfer", 0, 8'hA5, 1'b1);
    tick();
    check_idle("t1_rel");

    // Full contention from reset: 0,1,2,3,0 with an IDLE cycle between.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111; bus_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      push(k % N, 8'h10 + 8'(k % N));
      check_idle("t2_gap");
      tick();
      check_xfer("t2_xfer", k % N, 8'h10 + 8'(k % N), 1'b1);
      tick();
    end
    req = 4'b0000;
    check_idle("t2_end");

    // Pointer is now 1: owner 2 stalls on bus_ready for 5 cycles.
    tick();
    req = 4'b0100; bus_ready = 1'b0; set_data(2, 8'h3C);
    push(2, 8'h3C);
    check_idle("t3_idle");
    tick();
    for (int k = 0; k < 5; k++) begin
      check_xfer("t3_stall", 2, 8'h3C, 1'b0);
      tick();
    end
    bus_ready = 1'b1;
    check_xfer("t3_beat", 2, 8'h3C, 1'b1);
    tick();
    req = 4'b0000; bus_ready = 1'b0;
    check_idle("t3_rel");

    // Pointer is now 3: owner 1 aborts, then 2 wins the next arbitration.
    tick();
    req = 4'b0010; set_data(1, 8'h5A);
    check_idle("t4_idle");
    tick();
    check_xfer("t4_xfer", 1, 8'h5A, 1'b0);
    req = 4'b0000;
    #1;
    chk("t4_drop_valid", 32'(bus_valid), 1);
    tick();
    req = 4'b0111; bus_ready = 1'b1; set_data(2, 8'h77);
    push(2, 8'h77);
    check_idle("t4_abort");
    tick();
    check_xfer("t4_next", 2, 8'h77, 1'b1);
    req = 4'b0000;
    tick();
    check_idle("t4_rel");

    // Pointer is now 3: locked requester 3.
    tick();
    req = 4'b1000; lock = 4'b1000; bus_ready = 1'b1; set_data(3, 8'hC3);
`ifdef SIMPLE_BUS_ARB_LOCK_EN
    for (int k = 0; k < MB; k++) push(3, 8'hC3);
    check_idle("t5_idle");
    tick();
    for (int k = 0; k < MB; k++) begin
      check_xfer("t5_burst", 3, 8'hC3, 1'b1);
      tick();
    end
    req = 4'b0000; lock = 4'b0000;
    check_idle("t5_rel");
`else
    push(3, 8'hC3);
    check_idle("t5_idle");
    tick();
    check_xfer("t5_beat", 3, 8'hC3, 1'b1);
    tick();
    req = 4'b0000; lock = 4'b0000;
    check_idle("t5_rel");
`endif

    // Asynchronous reset mid-XFER, then the pointer restarts at 0.
    tick();
    req = 4'b0001; bus_ready = 1'b0; set_data(0, 8'h11);
    check_idle("t6_idle");
    tick();
    check_xfer("t6_xfer", 0, 8'h11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 0);
    chk("t6_async_valid", 32'(bus_valid), 0);
    chk("t6_async_data", 32'(bus_data), 0);
    chk("t6_async_owner", 32'(owner), 0);
    req = 4'b0110; bus_ready = 1'b1; set_data(1, 8'h66); set_data(2, 8'h99);
    tick();
    rst_n = 1'b1;
    push(1, 8'h66);
    check_idle("t6_post");
    tick();
    check_xfer("t6_win", 1, 8'h66, 1'b1);
    req = 4'b0000;
    tick();
    check_idle("t6_rel");

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
